// File: rtl/seq_stim_pkg.sv
// Shared types for the serial A transmitter: FSM states, receiver-model state,
// and the receiver-model next-state function, which the bench also uses.
package seq_stim_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    typedef logic [1:0] model_state_t;

    // 2-bit up/down counter: counts up when a=0 and down when a=1
    function automatic model_state_t model_next(input model_state_t s, input logic a);
        return {s[1] ^ s[0] ^ a, ~s[0]};
    endfunction

endpackage

// File: rtl/seq_stim_tx_if.sv
// Word-in / bit-out port bundle of seq_stim_tx. The slave modport is the
// transmitter; the master modport is the producer that also observes the serial side.
interface seq_stim_tx_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             a;
    logic             a_valid;
    logic             sof;
    logic             eof;

    modport master (
        output in_valid, in_data,
        input  in_ready, a, a_valid, sof, eof
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, a, a_valid, sof, eof
    );
endinterface

// File: rtl/seq_rx_model.sv
// Reference model of the 2-bit up/down counter receiver. It advances once per
// valid serial bit and registers Y (count==3) of the new state.
module seq_rx_model
    import seq_stim_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_adv,
    input  logic i_a,
    output logic o_y
);
    model_state_t r_s;
    model_state_t w_s_next;
    logic         r_y;

    always_comb begin
        w_s_next = model_next(r_s, i_a);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s <= '0;
            r_y <= 1'b0;
        end else if (i_adv) begin
            r_s <= w_s_next;
            r_y <= w_s_next[1] & w_s_next[0];
        end
    end

    assign o_y = r_y;
endmodule

// File: rtl/seq_stim_tx.sv
// One-word-buffered serialiser driving the serial A line with a_valid/sof/eof framing.
// Define SEQ_STIM_MODEL_EN to build in the receiver model that drives y_exp.
module seq_stim_tx
    import seq_stim_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_A    = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_stim_tx_if.slave bus,
    input  logic         stall,
    output logic         busy,
    output logic         y_exp
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef logic [WIDTH-1:0] word_t;

    state_e           r_state,   w_state_next;
    word_t            r_buf;
    logic             r_buf_vld, w_buf_vld_next;
    word_t            r_sh,      w_sh_next, w_sh_shifted;
    logic [CNT_W-1:0] r_cnt,     w_cnt_next;
    logic             r_a,       w_a_next;
    logic             w_accept, w_advance, w_last, w_load;

    function automatic logic head(input word_t w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign w_accept  = bus.in_valid & ~r_buf_vld;
    assign w_advance = (r_state == SHIFT) & ~stall;
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    // accept and load never coincide: accept needs an empty buffer, load a full one
    assign w_load    = r_buf_vld & ((r_state == IDLE) | (w_advance & w_last));
    assign w_sh_shifted = MSB_FIRST ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};

    always_comb begin
        w_state_next   = r_state;
        w_sh_next      = r_sh;
        w_cnt_next     = r_cnt;
        w_a_next       = r_a;
        w_buf_vld_next = r_buf_vld;

        if (w_accept) begin
            w_buf_vld_next = 1'b1;
        end else if (w_load) begin
            w_buf_vld_next = 1'b0;
        end

        if (w_load) begin
            w_state_next = SHIFT;
            w_sh_next    = r_buf;
            w_cnt_next   = '0;
            w_a_next     = head(r_buf);
        end else if (w_advance) begin
            if (w_last) begin
                w_state_next = IDLE;
                w_a_next     = IDLE_A;
            end else begin
                w_sh_next  = w_sh_shifted;
                w_cnt_next = r_cnt + CNT_W'(1);
                w_a_next   = head(w_sh_shifted);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_buf     <= '0;
            r_buf_vld <= 1'b0;
            r_sh      <= '0;
            r_cnt     <= '0;
            r_a       <= IDLE_A;
        end else begin
            r_state   <= w_state_next;
            r_buf_vld <= w_buf_vld_next;
            r_sh      <= w_sh_next;
            r_cnt     <= w_cnt_next;
            r_a       <= w_a_next;
            if (w_accept) begin
                r_buf <= bus.in_data;
            end
        end
    end

    // a is a flop; the framing flags are gated by stall in the same cycle
    assign bus.in_ready = ~r_buf_vld;
    assign bus.a        = r_a;
    assign bus.a_valid  = w_advance;
    assign bus.sof      = w_advance & (r_cnt == '0);
    assign bus.eof      = w_advance & w_last;
    assign busy         = (r_state == SHIFT) | r_buf_vld;

`ifdef SEQ_STIM_MODEL_EN
    seq_rx_model u_model (
        .clk   (clk),
        .rst_n (rst_n),
        .i_adv (w_advance),
        .i_a   (r_a),
        .o_y   (y_exp)
    );
`else
    assign y_exp = 1'b0;
`endif
endmodule

// File: tb/tb_seq_stim_tx.sv
// Bench for seq_stim_tx (WIDTH=8, MSB first, IDLE_A=0): scoreboard of expected serial
// bits plus hand sequences for latency, back-to-back, stall, buffer-full and reset.
module tb_seq_stim_tx;
    import seq_stim_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;
    logic busy;
    logic y_exp;

    seq_stim_tx_if #(.WIDTH(W)) bus ();

    seq_stim_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_A(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .stall (stall),
        .busy  (busy),
        .y_exp (y_exp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic a;
        logic sof;
        logic eof;
    } exp_t;

    typedef struct {
        logic [7:0] din;
        logic [7:0] serial;   // expected line order, leftmost bit first
    } vec_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int run_len = 0;
    int last_run = 0;
    int word_bits = 0;
    int last_word_bits = 0;

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // scoreboard consumer: one pop per valid serial bit
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.a_valid) begin
                if (sb.size() == 0) begin
                    chk1("sb_underflow", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk1("bit_a", bus.a, e.a);
                    chk1("bit_sof", bus.sof, e.sof);
                    chk1("bit_eof", bus.eof, e.eof);
                    $display("bit a=%b sof=%b eof=%b y_exp=%b", bus.a, bus.sof, bus.eof, y_exp);
                end
                run_len++;
                word_bits = bus.sof ? 1 : word_bits + 1;
                if (bus.eof) last_word_bits = word_bits;
`ifndef SEQ_STIM_MODEL_EN
                chk1("y_exp_off", y_exp, 1'b0);
`endif
            end else begin
                chk1("sof_unqualified", bus.sof, 1'b0);
                chk1("eof_unqualified", bus.eof, 1'b0);
                if (run_len != 0) last_run = run_len;
                run_len = 0;
            end
        end
    end

    // called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic send_word(input logic [7:0] d, input logic [7:0] ser);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk1("in_ready_timeout", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int i = 0; i < 8; i++)
            sb.push_back('{a: ser[7-i], sof: (i == 0), eof: (i == 7)});
        $display("send word=%h", d);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || sb.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) chk1("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        logic y_seq[8];
        vecs[0] = '{din: 8'hB4, serial: 8'b10110100};
        vecs[1] = '{din: 8'h0F, serial: 8'b00001111};
        vecs[2] = '{din: 8'h81, serial: 8'b10000001};
        vecs[3] = '{din: 8'h3C, serial: 8'b00111100};
        vecs[4] = '{din: 8'hE6, serial: 8'b11100110};
        y_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_a", bus.a, 1'b0);
        chk1("rst_a_valid", bus.a_valid, 1'b0);
        chk1("rst_sof", bus.sof, 1'b0);
        chk1("rst_eof", bus.eof, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_y_exp", y_exp, 1'b0);
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef SEQ_STIM_MODEL_EN
        // receiver model trace for 0F right after reset
        send_word(8'h0F, 8'b00001111);
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk1("model_y_exp", y_exp, y_seq[k]);
        end
        wait_idle();
`endif

        for (int v = 0; v < 5; v++) begin
            send_word(vecs[v].din, vecs[v].serial);
            wait_idle();
            chkn("table_word_bits", last_word_bits, 8);
        end

        // first bit two edges after accept
        send_word(8'hB4, 8'b10110100);
        chk1("lat_a_valid_e0", bus.a_valid, 1'b0);
        chk1("lat_in_ready_e0", bus.in_ready, 1'b0);
        @(posedge clk); #1;
        chk1("lat_a_valid_e1", bus.a_valid, 1'b1);
        chk1("lat_sof_e1", bus.sof, 1'b1);
        chk1("lat_a_e1", bus.a, 1'b1);
        wait_idle();

        // back-to-back words stream without a gap
        send_word(8'hFF, 8'b11111111);
        send_word(8'h00, 8'b00000000);
        wait_idle();
        @(negedge clk); #1;
        chkn("b2b_run_len", last_run, 16);

        // two-cycle stall on bit 3 of 5A
        send_word(8'h5A, 8'b01011010);
        repeat (4) @(posedge clk);
        #1;
        stall = 1'b1;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            chk1("stall_a_valid", bus.a_valid, 1'b0);
            chk1("stall_a_held", bus.a, 1'b1);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(negedge clk);
        chk1("stall_resume_valid", bus.a_valid, 1'b1);
        chk1("stall_resume_a", bus.a, 1'b1);
        wait_idle();
        chkn("stall_word_bits", last_word_bits, 8);

        // buffer full: toggling data must not disturb the buffered word
        send_word(8'hC3, 8'b11000011);
        send_word(8'h3C, 8'b00111100);
        for (int t = 0; t < 5; t++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = t[0] ? 8'h55 : 8'hAA;
            @(negedge clk);
            chk1("full_in_ready", bus.in_ready, 1'b0);
            chk1("full_busy", busy, 1'b1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        wait_idle();

        // reset held three cycles while bit 3 is on the line
        send_word(8'hC5, 8'b11000101);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        @(negedge clk);
        chk1("midrst_a", bus.a, 1'b0);
        chk1("midrst_a_valid", bus.a_valid, 1'b0);
        chk1("midrst_in_ready", bus.in_ready, 1'b1);
        chk1("midrst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_word(8'h96, 8'b10010110);
        @(posedge clk); #1;
        chk1("postrst_sof", bus.sof, 1'b1);
        chk1("postrst_a_valid", bus.a_valid, 1'b1);
        wait_idle();

        chkn("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
